// File: rtl/jstk_spi_responder_pkg.sv
// Shared definitions for the joystick SPI responder: FSM states, frame
// geometry, LED command prefix and the frame packing function.
package jstk_spi_responder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int FRAME_BITS = 40;
    localparam int CMD_BITS   = 8;
    localparam int CNT_W      = 6;

    // Counter value of the final frame bit, and the number of command bits,
    // pre-sized to the counter width so comparisons stay width-matched.
    localparam logic [CNT_W-1:0] LAST_BIT = 6'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] CMD_CNT  = 6'(CMD_BITS);

    localparam logic [5:0] LED_PREFIX = 6'b100000;

    // Packs the joystick state into the 40-bit frame, low byte of each axis first.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [9:0] x,
        input logic [9:0] y,
        input logic [2:0] b
    );
        return {x[7:0], 6'b0, x[9:8], y[7:0], 6'b0, y[9:8], 5'b0, b};
    endfunction

endpackage

// File: rtl/jstk_spi_responder_if.sv
// SPI bus bundle between the master and the joystick responder.
interface jstk_spi_responder_if;
    logic SS;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS, output SCLK, output MOSI, input MISO);
    modport slave  (input SS, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/jstk_spi_responder_spi_in_sync.sv
// Multi-flop synchronizer for one asynchronous SPI input, with single-cycle
// rise/fall pulses derived from the synchronized level. The chain resets to
// 0 so an input already low at reset release produces no falling edge.
module spi_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    // Shift the raw input through the chain and remember the last synchronized level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign dout = chain[SYNC_STAGES-1];
    assign rise = dout & ~prev;
    assign fall = ~dout & prev;
endmodule

// File: rtl/jstk_spi_responder.sv
// Joystick SPI responder: returns a 40-bit position/button frame to an SPI
// mode-0 master. Optional feature macro JSTK_LED_CMD_EN enables decoding of
// the first received byte as an LED command (8'b100000xx).
module jstk_spi_responder
    import jstk_spi_responder_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    jstk_spi_responder_if.slave        spi,
    input  logic [9:0]                 x_pos,
    input  logic [9:0]                 y_pos,
    input  logic [2:0]                 buttons,
    output logic [1:0]                 leds,
    output logic                       frame_done
);
    logic ss_lvl, ss_rise, ss_fall;
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;

    state_t                state, state_nxt;
    logic [FRAME_BITS-1:0] shreg;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  load;
    logic                  frame_end;

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
        .clk(clk), .rst_n(rst_n), .din(spi.SS),
        .dout(ss_lvl), .rise(ss_rise), .fall(ss_fall)
    );

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .din(spi.SCLK),
        .dout(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .din(spi.MOSI),
        .dout(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
    );

    // Frame starts on SS falling in IDLE; a completed frame ends on SS rising in DONE.
    assign load      = (state == IDLE) && ss_fall;
    assign frame_end = (state == DONE) && ss_rise;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; SCLK is only acted on while a frame is open, so
    // edges with SS high never leave IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (ss_fall) state_nxt = SHIFT;
            SHIFT: begin
                if (ss_rise)                               state_nxt = IDLE;
                else if (sclk_rise && bit_cnt == LAST_BIT) state_nxt = DONE;
            end
            DONE:  if (ss_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Frame shift register and bit counter: load snapshots the inputs, SCLK
    // falls shift out MSB first with zero fill, SCLK rises count bits in SHIFT only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            shreg   <= build_frame(x_pos, y_pos, buttons);
            bit_cnt <= '0;
        end else begin
            if ((state != IDLE) && sclk_fall)
                shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
            if ((state == SHIFT) && sclk_rise)
                bit_cnt <= bit_cnt + 6'd1;
        end
    end

    // One-cycle completion pulse, registered on the DONE->IDLE transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_done <= 1'b0;
        else        frame_done <= frame_end;
    end

    assign spi.MISO = (state != IDLE) & shreg[FRAME_BITS-1];

`ifdef JSTK_LED_CMD_EN
    logic [CMD_BITS-1:0] rx_byte;
    logic                unused_sync;

    // Capture the first eight MOSI bits of the frame on SCLK rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rx_byte <= '0;
        else if (load)
            rx_byte <= '0;
        else if ((state == SHIFT) && sclk_rise && (bit_cnt < CMD_CNT))
            rx_byte <= {rx_byte[CMD_BITS-2:0], mosi_lvl};
    end

    // Apply an LED command only when the frame completed normally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            leds <= 2'b00;
        else if (frame_end && (rx_byte[7:2] == LED_PREFIX))
            leds <= rx_byte[1:0];
    end

    assign unused_sync = ^{ss_lvl, sclk_lvl, mosi_rise, mosi_fall};
`else
    logic unused_sync;

    assign leds        = 2'b00;
    assign unused_sync = ^{ss_lvl, sclk_lvl, mosi_lvl, mosi_rise, mosi_fall};
`endif

endmodule
